// File: rtl/tpu_mmio_master.sv
// MMIO master that loads A/B (and optionally C) rows from a source buffer into a
// systolic TPU, triggers it, waits, and streams the 16 C result words out.
module tpu_mmio_master #(
  parameter int DIM      = 8,
  parameter int ADDRW    = 16,
  parameter int DATAW    = 64,
  parameter int WAIT_CYC = 3 * DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_c,
  output logic             busy,
  output logic             done,
  output logic             src_rd_en,
  output logic [4:0]       src_addr,
  input  logic [DATAW-1:0] src_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DATAW-1:0] res_data,
  output logic [3:0]       res_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_LOAD_C = 3'd3;
  localparam logic [2:0] S_TRIG   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_READ   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]       state_reg;
  logic             load_c_reg;
  logic             rd_en_reg;
  logic [4:0]       rd_idx_reg;
  logic             wr_en_reg;
  logic [4:0]       wr_idx_reg;
  logic [15:0]      wait_cnt_reg;
  logic [4:0]       rsp_idx_reg;
  logic             res_valid_reg;
  logic [DATAW-1:0] res_data_reg;
  logic [3:0]       res_idx_reg;
  logic [4:0]       last_idx;
  logic [4:0]       rd_idx_next;
  logic             capture;

  // Source word index -> MMIO address: A at 0x100, B at 0x200, C at 0x300, 8 bytes apart.
  function automatic logic [ADDRW-1:0] word_addr(input logic [4:0] idx);
    logic [10:0] a;
    if (idx[4]) a = {3'b011, 1'b0, idx[3:0], 3'b000};
    else        a = {1'b0, idx[3], ~idx[3], 2'b00, idx[2:0], 3'b000};
    return ADDRW'(a);
  endfunction

  assign last_idx    = load_c_reg ? 5'd31 : 5'd15;
  assign rd_idx_next = rd_idx_reg + 5'd1;
  assign capture     = (state_reg == S_READ) && !rsp_idx_reg[4] && (!res_valid_reg || res_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      load_c_reg    <= 1'b0;
      rd_en_reg     <= 1'b0;
      rd_idx_reg    <= 5'd0;
      wr_en_reg     <= 1'b0;
      wr_idx_reg    <= 5'd0;
      wait_cnt_reg  <= 16'd0;
      rsp_idx_reg   <= 5'd0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_idx_reg   <= 4'd0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_LOAD_A;
            load_c_reg <= load_c;
            rd_en_reg  <= 1'b1;
            rd_idx_reg <= 5'd0;
          end
        end
        S_LOAD_A, S_LOAD_B, S_LOAD_C: begin
          // Read of word k and write of word k-1 overlap; one drain cycle after the last read.
          wr_en_reg  <= rd_en_reg;
          wr_idx_reg <= rd_idx_reg;
          if (rd_en_reg) begin
            if (rd_idx_reg == last_idx) begin
              rd_en_reg <= 1'b0;
            end else begin
              rd_idx_reg <= rd_idx_next;
              if (rd_idx_next == 5'd8)  state_reg <= S_LOAD_B;
              if (rd_idx_next == 5'd16) state_reg <= S_LOAD_C;
            end
          end else begin
            state_reg <= S_TRIG;
          end
        end
        S_TRIG: begin
          wait_cnt_reg <= 16'd0;
          rsp_idx_reg  <= 5'd0;
          state_reg    <= (WAIT_CYC == 0) ? S_READ : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_reg == 16'(WAIT_CYC - 1)) state_reg <= S_READ;
          else wait_cnt_reg <= wait_cnt_reg + 16'd1;
        end
        S_READ: begin
          if (capture) begin
            res_data_reg  <= tpu_dataOut;
            res_idx_reg   <= rsp_idx_reg[3:0];
            res_valid_reg <= 1'b1;
            rsp_idx_reg   <= rsp_idx_reg + 5'd1;
          end else if (res_valid_reg && res_ready) begin
            res_valid_reg <= 1'b0;
            if (rsp_idx_reg[4]) state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The write data path is combinational from src_data, which arrives the cycle after the read strobe.
  always_comb begin
    tpu_r_w    = 1'b0;
    tpu_addr   = '0;
    tpu_dataIn = '0;
    if (wr_en_reg) begin
      tpu_r_w    = 1'b1;
      tpu_addr   = word_addr(wr_idx_reg);
      tpu_dataIn = src_data;
    end else if (state_reg == S_TRIG) begin
      tpu_r_w  = 1'b1;
      tpu_addr = ADDRW'(16'h0400);
    end else if ((state_reg == S_READ) && !rsp_idx_reg[4]) begin
      tpu_addr = word_addr({1'b1, rsp_idx_reg[3:0]});
    end
  end

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done      = (state_reg == S_DONE);
  assign src_rd_en = rd_en_reg;
  assign src_addr  = rd_idx_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_idx   = res_idx_reg;

endmodule

// File: tb/tb_tpu_mmio_master.sv
// Directed bench for tpu_mmio_master with a source buffer model and a TPU MMIO responder.
module tb_tpu_mmio_master;
  logic        clk = 1'b0;
  logic        rst, start, load_c, res_ready;
  logic        busy, done, src_rd_en, tpu_r_w, res_valid;
  logic [4:0]  src_addr;
  logic [15:0] tpu_addr;
  logic [63:0] src_data, tpu_dataIn, tpu_dataOut, res_data;
  logic [3:0]  res_idx;

  tpu_mmio_master #(.DIM(8), .ADDRW(16), .DATAW(64), .WAIT_CYC(24)) dut (
    .clk(clk), .rst(rst), .start(start), .load_c(load_c), .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input int k);
    return 64'h1111_1111_1111_1111 * 64'(k % 15 + 1);
  endfunction

  function automatic logic [15:0] waddr(input int k);
    if (k < 8)       return 16'(16'h100 + 8 * k);
    else if (k < 16) return 16'(16'h200 + 8 * (k - 8));
    else             return 16'(16'h300 + 8 * (k - 16));
  endfunction

  // Source buffer: registered read. TPU responder: write stores, read is combinational.
  logic [63:0] mem [0:255];
  always @(posedge clk) src_data <= src_rd_en ? pat(int'(src_addr)) : 64'd0;
  always @(posedge clk) if (tpu_r_w && tpu_addr < 16'h400) mem[tpu_addr[10:3]] <= tpu_dataIn;
  assign tpu_dataOut = mem[tpu_addr[10:3]];

  typedef struct {int c; logic rw; logic [15:0] a; logic [63:0] d;} ev_t;
  ev_t         evq[$];
  logic [63:0] resd_q[$];
  int          resi_q[$];
  int          resc_q[$];
  int          done_cnt = 0, done_cyc = 0, rd_cnt = 0, rd_hi_cnt = 0;
  logic        busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (tpu_r_w || tpu_addr != 16'h0 || tpu_dataIn != 64'h0)
      evq.push_back(ev_t'{cyc, tpu_r_w, tpu_addr, tpu_dataIn});
    if (res_valid && res_ready) begin
      resd_q.push_back(res_data);
      resi_q.push_back(int'(res_idx));
      resc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (src_rd_en) begin
      rd_cnt++;
      if (src_addr >= 5'd16) rd_hi_cnt++;
    end
  end

  int total = 0, passed = 0, t0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    evq.delete(); resd_q.delete(); resi_q.delete(); resc_q.delete();
    rd_cnt = 0; rd_hi_cnt = 0;
  endtask

  task automatic launch(input logic lc);
    start = 1'b1; load_c = lc; t0 = cyc;
    tick(1);
    start = 1'b0; load_c = 1'b0;
    chk("busy_cycle1", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 300) begin
      tick(1);
      n++;
    end
    chk("done_seen", 64'(done_cnt), 64'(base + 1));
  endtask

  // Full bus / result / done timeline of an unthrottled job.
  task automatic check_job(input logic lc);
    int n = lc ? 32 : 16;
    int e_c; logic e_rw; logic [15:0] e_a; logic [63:0] e_d;
    chk("ev_count", 64'(evq.size()), 64'(n + 17));
    for (int i = 0; i < evq.size() && i < n + 17; i++) begin
      if (i < n) begin
        e_c = i + 2; e_rw = 1'b1; e_a = waddr(i); e_d = pat(i);
      end else if (i == n) begin
        e_c = n + 2; e_rw = 1'b1; e_a = 16'h0400; e_d = 64'd0;
      end else begin
        e_c = n + 27 + (i - n - 1); e_rw = 1'b0; e_a = 16'(16'h300 + 8 * (i - n - 1)); e_d = 64'd0;
      end
      chk($sformatf("ev%0d_cyc_rw_addr", i), {32'(evq[i].c - t0), 15'd0, evq[i].rw, evq[i].a},
          {32'(e_c), 15'd0, e_rw, e_a});
      chk($sformatf("ev%0d_data", i), evq[i].d, e_d);
    end
    chk("res_count", 64'(resd_q.size()), 64'd16);
    for (int i = 0; i < resd_q.size() && i < 16; i++) begin
      chk($sformatf("res%0d_idx", i), 64'(resi_q[i]), 64'(i));
      chk($sformatf("res%0d_data", i), resd_q[i], pat(16 + i));
      chk($sformatf("res%0d_cyc", i), 64'(resc_q[i] - t0), 64'(n + 28 + i));
    end
    chk("done_cyc", 64'(done_cyc - t0), 64'(n + 44));
    chk("busy_at_done", 64'(busy_at_done), 64'd0);
    chk("src_rd_cnt", 64'(rd_cnt), 64'(n));
    chk("src_rd_hi", 64'(rd_hi_cnt), lc ? 64'd16 : 64'd0);
  endtask

  initial begin
    int base, n;
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    rst = 1'b1; start = 1'b0; load_c = 1'b0; res_ready = 1'b1;
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(src_rd_en), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_idx", 64'(res_idx), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_bus", {tpu_dataIn, 15'd0, tpu_r_w, tpu_addr}, 96'd0);
    rst = 1'b0;
    tick(2);

    // Job 1: with C preload
    clr(); base = done_cnt;
    launch(1'b1);
    wait_done(base);
    check_job(1'b1);
    tick(3);

    // Job 2: no C preload (C words remain from job 1 in the responder)
    clr(); base = done_cnt;
    launch(1'b0);
    wait_done(base);
    check_job(1'b0);
    tick(3);

    // Job 3: backpressure on idx 5
    clr(); base = done_cnt;
    launch(1'b1);
    n = 0;
    while (!(res_valid && res_idx == 4'd5) && n < 200) begin
      tick(1);
      n++;
    end
    chk("bp_reach_idx5", 64'(res_idx), 64'd5);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_valid", k), 64'(res_valid), 64'd1);
      chk($sformatf("bp%0d_idx", k), 64'(res_idx), 64'd5);
      chk($sformatf("bp%0d_data", k), res_data, pat(21));
      chk($sformatf("bp%0d_pending_addr", k), 64'(tpu_addr), 64'h330);
      if (k < 2) tick(1);
    end
    tick(1);
    res_ready = 1'b1;
    chk("bp_still_idx5", 64'(res_idx), 64'd5);
    tick(1);
    chk("bp_next_idx6", 64'(res_idx), 64'd6);
    wait_done(base);
    chk("bp_res_count", 64'(resd_q.size()), 64'd16);
    for (int i = 0; i < resd_q.size() && i < 16; i++) begin
      chk($sformatf("bp_res%0d_idx", i), 64'(resi_q[i]), 64'(i));
      chk($sformatf("bp_res%0d_data", i), resd_q[i], pat(16 + i));
    end
    tick(3);

    // Job 4: start pulses during WAIT and READ are ignored
    clr(); base = done_cnt;
    launch(1'b0);
    tick(25);
    start = 1'b1; load_c = 1'b1;
    tick(1);
    start = 1'b0; load_c = 1'b0;
    tick(23);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(base);
    check_job(1'b0);
    tick(20);
    chk("single_done", 64'(done_cnt), 64'(base + 1));
    chk("idle_busy", 64'(busy), 64'd0);

    // Job 5: reset during LOAD_B aborts the job
    clr(); base = done_cnt;
    launch(1'b1);
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_bus", {tpu_dataIn, 15'd0, tpu_r_w, tpu_addr}, 96'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_en", 64'(src_rd_en), 64'd0);
    evq.delete();
    tick(60);
    chk("abort_no_bus", 64'(evq.size()), 64'd0);
    chk("abort_no_done", 64'(done_cnt), 64'(base));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
